// File: rtl/fill_arb_pkg.sv
// Shared definitions for the N-channel fill arbiter.
// Holds the arbitration-mode encodings, the default payload layout and a
// helper that sizes channel-index fields.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif

package fill_arb_pkg;

    // Arbitration modes: rotating priority or lowest-index-wins.
    localparam logic ARB_RR    = 1'b0;
    localparam logic ARB_FIXED = 1'b1;

    // Default payload field widths taken from the bus configuration.
    localparam int DEF_ADDR_W = `AXI_ADDR_WIDTH;
    localparam int DEF_DATA_W = `AXI_DATA_WIDTH;

    // Payload layout at the default widths; address occupies the upper bits.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } fill_payload_t;

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_width(input int n);
        int w;
        w = 1;
        if (n > 2) begin
            w = $clog2(n);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/fill_arbiter_nch_picker.sv
// arb_rr_picker: selects one requesting channel per cycle.
// Ports:
//   clk, rst_n  - clock and synchronous active-low reset
//   req         - per-channel request vector
//   advance     - the current winner was accepted; move the pointer onto it
//   grant       - one-hot winner (zero when nothing requests)
//   winner      - index of the winner
// In rotating mode the search starts just after the last accepted channel
// and wraps modulo NUM_CH, so non-power-of-two channel counts never produce
// an index beyond NUM_CH-1. In fixed mode the lowest index wins and the
// pointer stays at its reset value.
module arb_rr_picker
    import fill_arb_pkg::*;
#(
    parameter int   NUM_CH   = 2,
    parameter logic ARB_MODE = ARB_RR,
    localparam int  CH_W     = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   winner
);

    logic [CH_W-1:0] ptr_r;
    logic [CH_W-1:0] cand_s;
    logic [CH_W-1:0] win_s;
    logic            found_s;

    // Priority search: walk candidates in priority order, keep the first hit.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        cand_s  = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (ARB_MODE == ARB_FIXED) begin
                cand_s = CH_W'(k - 1);
            end else begin
                cand_s = CH_W'((int'(ptr_r) + k) % NUM_CH);
            end
            if (!found_s && req[cand_s]) begin
                found_s = 1'b1;
                win_s   = cand_s;
            end else begin
                found_s = found_s;
                win_s   = win_s;
            end
        end
    end

    // One-hot grant decode of the winner.
    always_comb begin
        grant = '0;
        if (found_s) begin
            grant[win_s] = 1'b1;
        end else begin
            grant = '0;
        end
    end

    assign winner = win_s;

    // Rotation pointer: remembers the last accepted channel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r <= CH_W'(NUM_CH - 1);
        end else if (advance && (ARB_MODE == ARB_RR)) begin
            ptr_r <= win_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/fill_arbiter_nch.sv
// fill_arbiter_nch: merges NUM_CH fill-write request streams into the single
// fill FIFO through a one-entry output register.
// Ports:
//   clk, rst_n    - clock and synchronous active-low reset
//   req_valid_i   - per-channel request valid
//   req_ready_o   - per-channel accept strobe (one-hot or zero)
//   req_data_i    - packed per-channel payloads, channel i at [i*PAYLOAD_W +: PAYLOAD_W]
//   fifo_afull_i  - fill FIFO almost-full
//   fifo_wren_o   - fill FIFO write enable
//   fifo_data_o   - fill FIFO write data (output register)
//   grant_ch_o    - channel index of the entry in the output register
//   busy_o        - output register holds an entry
// Accept and drain share the !fifo_afull_i qualifier, so an undrained entry
// is never overwritten, and when both happen in one cycle the register is
// refilled immediately, sustaining one write per cycle.
module fill_arbiter_nch
    import fill_arb_pkg::*;
#(
    parameter int   ADDR_WIDTH = `AXI_ADDR_WIDTH,
    parameter int   DATA_WIDTH = `AXI_DATA_WIDTH,
    parameter int   NUM_CH     = 2,
    parameter logic ARB_MODE   = ARB_RR,
    localparam int  PAYLOAD_W  = ADDR_WIDTH + DATA_WIDTH,
    localparam int  CH_W       = ch_width(NUM_CH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           req_valid_i,
    output logic [NUM_CH-1:0]           req_ready_o,
    input  logic [NUM_CH*PAYLOAD_W-1:0] req_data_i,
    input  logic                        fifo_afull_i,
    output logic                        fifo_wren_o,
    output logic [PAYLOAD_W-1:0]        fifo_data_o,
    output logic [CH_W-1:0]             grant_ch_o,
    output logic                        busy_o
);

    logic [NUM_CH-1:0]    grant_s;
    logic [CH_W-1:0]      win_s;
    logic [PAYLOAD_W-1:0] win_data_s;
    logic                 accept_s;
    logic                 drain_s;
    logic                 out_valid_r;
    logic [PAYLOAD_W-1:0] data_r;
    logic [CH_W-1:0]      ch_r;

    assign accept_s = (|req_valid_i) & ~fifo_afull_i;
    assign drain_s  = out_valid_r & ~fifo_afull_i;

    arb_rr_picker #(
        .NUM_CH   (NUM_CH),
        .ARB_MODE (ARB_MODE)
    ) u_picker (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid_i),
        .advance (accept_s),
        .grant   (grant_s),
        .winner  (win_s)
    );

    // Ready strobe goes only to the winner and only when an accept happens.
    always_comb begin
        req_ready_o = '0;
        if (accept_s) begin
            req_ready_o = grant_s;
        end else begin
            req_ready_o = '0;
        end
    end

    // Payload mux driven by the one-hot grant.
    always_comb begin
        win_data_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_s[i]) begin
                win_data_s = req_data_i[i*PAYLOAD_W +: PAYLOAD_W];
            end else begin
                win_data_s = win_data_s;
            end
        end
    end

    // Output register: refill on accept, empty on drain-only, else hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            data_r      <= '0;
            ch_r        <= '0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            data_r      <= win_data_s;
            ch_r        <= win_s;
        end else if (drain_s) begin
            out_valid_r <= 1'b0;
            data_r      <= data_r;
            ch_r        <= ch_r;
        end else begin
            out_valid_r <= out_valid_r;
            data_r      <= data_r;
            ch_r        <= ch_r;
        end
    end

    assign fifo_wren_o = drain_s;
    assign fifo_data_o = data_r;
    assign grant_ch_o  = ch_r;
    assign busy_o      = out_valid_r;

endmodule

// File: tb/tb_fill_arbiter_nch.sv
// Randomized bench for fill_arbiter_nch. Three instances run side by side:
// 4 channels rotating, 4 channels fixed priority, 3 channels rotating.
// A transaction-level model tracks the last accepted channel, the entry held
// for the FIFO and the pending request of every source.
module tb_fill_arbiter_nch;
    import fill_arb_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int PW = AW + DW;
    localparam int NU = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic afull = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]    vld [NU];
    logic [PW-1:0] dat [NU][4];

    logic [3:0]    rdy [NU];
    logic [2:0]    rdy2_s;
    logic [NU-1:0] wren;
    logic [NU-1:0] busy;
    logic [PW-1:0] fd [NU];
    logic [1:0]    gch [NU];

    assign rdy[2] = {1'b0, rdy2_s};

    fill_arbiter_nch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(4), .ARB_MODE(ARB_RR)) u_rr4 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(vld[0]), .req_ready_o(rdy[0]),
        .req_data_i({dat[0][3], dat[0][2], dat[0][1], dat[0][0]}),
        .fifo_afull_i(afull), .fifo_wren_o(wren[0]), .fifo_data_o(fd[0]),
        .grant_ch_o(gch[0]), .busy_o(busy[0]));

    fill_arbiter_nch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(4), .ARB_MODE(ARB_FIXED)) u_fx4 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(vld[1]), .req_ready_o(rdy[1]),
        .req_data_i({dat[1][3], dat[1][2], dat[1][1], dat[1][0]}),
        .fifo_afull_i(afull), .fifo_wren_o(wren[1]), .fifo_data_o(fd[1]),
        .grant_ch_o(gch[1]), .busy_o(busy[1]));

    fill_arbiter_nch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(3), .ARB_MODE(ARB_RR)) u_rr3 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(vld[2][2:0]), .req_ready_o(rdy2_s),
        .req_data_i({dat[2][2], dat[2][1], dat[2][0]}),
        .fifo_afull_i(afull), .fifo_wren_o(wren[2]), .fifo_data_o(fd[2]),
        .grant_ch_o(gch[2]), .busy_o(busy[2]));

    // Reference model state per instance.
    int            nch   [NU] = '{4, 4, 3};
    bit            fixed [NU] = '{1'b0, 1'b1, 1'b0};
    int            last  [NU];
    bit            held  [NU];
    logic [PW-1:0] hdata [NU];
    int            hch   [NU];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Winner by the arbitration rule, -1 when nothing requests.
    function automatic int pick(input int u, input logic [3:0] v);
        if (fixed[u]) begin
            for (int c = 0; c < nch[u]; c++)
                if (v[c]) return c;
        end else begin
            for (int k = 1; k <= nch[u]; k++)
                if (v[(last[u] + k) % nch[u]]) return (last[u] + k) % nch[u];
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < NU; u++) begin
            last[u]  = nch[u] - 1;
            held[u]  = 1'b0;
            hdata[u] = '0;
            hch[u]   = 0;
            vld[u]   = 4'b0000;
        end
    endtask

    // One clock cycle: drive sources, check outputs, advance the model.
    task automatic step(input int p_valid, input int p_afull, input bit do_rst);
        int         win [NU];
        logic [3:0] exp_rdy;
        @(negedge clk);
        rst_n = !do_rst;
        afull = ($urandom_range(99) < p_afull);
        for (int u = 0; u < NU; u++)
            for (int c = 0; c < nch[u]; c++)
                if (!vld[u][c] && ($urandom_range(99) < p_valid)) begin
                    vld[u][c] = 1'b1;
                    dat[u][c] = PW'($urandom);
                end
        #1;
        for (int u = 0; u < NU; u++) begin
            win[u] = pick(u, vld[u]);
            if (!do_rst) begin
                exp_rdy = 4'b0000;
                if (win[u] >= 0 && !afull) exp_rdy[win[u]] = 1'b1;
                check_eq($sformatf("u%0d ready", u), 32'(rdy[u]), 32'(exp_rdy));
                check_eq($sformatf("u%0d wren", u), 32'(wren[u]), 32'(held[u] && !afull));
                check_eq($sformatf("u%0d busy", u), 32'(busy[u]), 32'(held[u]));
                check_eq($sformatf("u%0d data", u), 32'(fd[u]), 32'(hdata[u]));
                check_eq($sformatf("u%0d grant_ch", u), 32'(gch[u]), 32'(hch[u]));
            end
        end
        @(posedge clk);
        #1;
        if (do_rst) begin
            model_reset();
        end else begin
            for (int u = 0; u < NU; u++) begin
                if (win[u] >= 0 && !afull) begin
                    held[u]  = 1'b1;
                    hdata[u] = dat[u][win[u]];
                    hch[u]   = win[u];
                    vld[u][win[u]] = 1'b0;
                    if (!fixed[u]) last[u] = win[u];
                end else if (held[u] && !afull) begin
                    held[u] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        for (int u = 0; u < NU; u++)
            for (int c = 0; c < 4; c++) dat[u][c] = '0;
        model_reset();
        step(0, 0, 1'b1);
        step(0, 0, 1'b1);
        // idle after reset: reset values visible
        repeat (2) step(0, 0, 1'b0);
        // every source continuously valid, no back-pressure
        repeat (24) step(100, 0, 1'b0);
        // back-pressure held for five cycles with an entry pending
        repeat (5) step(100, 100, 1'b0);
        repeat (4) step(100, 0, 1'b0);
        // mixed random traffic
        repeat (300) step(40, 25, 1'b0);
        // reset while busy with requests pending
        step(100, 0, 1'b1);
        repeat (12) step(100, 0, 1'b0);
        repeat (200) step(20, 10, 1'b0);
        repeat (100) step(70, 50, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fill_arbiter_nch.md
Name: fill_arbiter_nch

Overview:
- N-channel successor to the two-source fill arbiter.
- Merges fill-write requests (tag-comparator hits, read-miss returns, writeback refills, ...) into the single fill FIFO.
- Grants in round-robin or fixed-priority mode and accepts one request per cycle.
- A one-entry output register feeds the FIFO, so there is no idle cycle between grants.

Parameters:
- ADDR_WIDTH, `AXI_ADDR_WIDTH, address field width of each request payload.
- DATA_WIDTH, `AXI_DATA_WIDTH, data field width of each request payload.
- NUM_CH, 2, number of requesting channels (2..16).
- ARB_MODE, ARB_RR, ARB_RR = rotating priority; ARB_FIXED = lowest channel index wins.
- PAYLOAD_W (localparam), ADDR_WIDTH+DATA_WIDTH.
- CH_W (localparam), max(1,$clog2(NUM_CH)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid_i  in  NUM_CH  per-channel request valid.
- req_ready_o  out  NUM_CH  per-channel accept strobe; one-hot or zero.
- req_data_i  in  NUM_CH*PAYLOAD_W  per-channel payload; channel i occupies bits [i*PAYLOAD_W +: PAYLOAD_W].
- fifo_afull_i  in  1  fill FIFO almost-full.
- fifo_wren_o  out  1  fill FIFO write enable.
- fifo_data_o  out  PAYLOAD_W  fill FIFO write data.
- grant_ch_o  out  CH_W  channel index of the entry held in the output register.
- busy_o  out  1  output register holds an entry.

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, fifo_data_o=0, grant_ch_o=0, RR pointer=NUM_CH-1 (channel 0 wins first). Outputs req_ready_o=0 and fifo_wren_o=0 follow. Any entry held in the output register is discarded; sources must also be reset.
- Handshake:
  - A transfer occurs when req_valid_i[i]&req_ready_o[i] at a clk edge.
  - req_ready_o is combinational from req_valid_i, fifo_afull_i and arbiter state.
  - Sources hold valid and data stable until accepted and must not wait on ready before raising valid.
- Accept condition: accept = |req_valid_i & !fifo_afull_i. When accept=1, exactly one ready bit is set, for the winner.
- Drain: fifo_wren_o = out_valid & !fifo_afull_i. Entries are written with 1-cycle latency.
- Pipelining:
  - Accept and drain may happen in the same cycle; the register is then overwritten with the new winner, giving a sustained 1 write/cycle.
  - Because both conditions require !fifo_afull_i, the register is never overwritten while undrained.
- Register update on an accepted request: out_valid<=1, fifo_data_o<=payload of the winner, grant_ch_o<=winner. On drain without accept: out_valid<=0, and data/grant_ch hold their last values.
- fifo_afull_i high: no accepts, no writes; the held entry stays put. When afull deasserts, the held entry is written and a new accept happens in the same cycle.
- Winner selection when ARB_RR:
  - Search starts at pointer+1 and wraps modulo NUM_CH.
  - The first valid channel wins; pointer<=winner, updated only on accept.
  - A continuously asserting channel waits at most NUM_CH-1 accepts.
- Winner selection when ARB_FIXED: lowest valid index wins; the pointer is unused and held at reset value.
- NUM_CH not a power of 2: the wrap must skip nonexistent indices. Example: NUM_CH=3 gives pointer sequence 0,1,2,0.
- Single requester: that channel is granted every cycle that afull=0, in both modes.
- No $display or other simulation output in synthesizable code.

Decomposition:
- Package fill_arb_pkg holds:
  - ARB_RR=1'b0, ARB_FIXED=1'b1.
  - Payload typedef helper, i.e. a struct of addr/data at the configured widths.
- One sub-module, arb_rr_picker:
  - Parameters NUM_CH and ARB_MODE.
  - Inputs req, advance; outputs a one-hot grant and the winner index.
  - Owns the pointer register.
- Top level holds the output register and handshake logic.

Test Plan:
- NUM_CH=4, ARB_RR, all four valid continuously, afull=0 -> grants in order 0,1,2,3,0,...; fifo_wren_o high every cycle from the second cycle; payload order matches.
- NUM_CH=4, ARB_FIXED, ch1 and ch3 valid continuously -> only ch1 granted; ch3 granted only after ch1 drops valid.
- NUM_CH=4, ARB_RR, one entry held, afull=1 for 5 cycles while ch2 valid -> no ready, no wren, fifo_data_o stable. Afull falls -> in the same cycle, held entry written and ch2 accepted; ch2 written the next cycle.
- NUM_CH=3, ARB_RR, all valid for 6 accepts -> pointer wraps 0,1,2,0,1,2, never an invalid index; grant_ch_o matches.
- NUM_CH=2, ARB_RR: ch0 valid cycles 0-3, ch1 valid from cycle 1 -> grants 0,1,0,1; each channel's data appears on fifo_data_o exactly once per accept (scoreboard check).
- rst_n low for 1 cycle while busy_o=1 and requests pending -> busy_o=0, fifo_wren_o=0, fifo_data_o=0 after the edge. First grant after reset goes to ch0.
